ransac_inlier_scorer: RTL and testbench
=======================================

Name: ransac_inlier_scorer

Overview:
- Sequences the point-to-line inlier test across a stored point set for one candidate line.
- Reads points from the point RAM at one point per cycle and counts inliers.
- Keeps the best-scoring line seen since the last clear.
- Sits between the Nios-visible RANSAC control registers and the point RAM; replaces per-point software calls to the inlier test.

Parameters:
- DATA_W, 32, width of coordinates, line coefficients, scale, threshold and all arithmetic
- ADDR_W, 10, point RAM address width; at most 2^ADDR_W points

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin scoring; sampled only in IDLE
- clear_best  in  1  clear best-line registers
- line_a  in  DATA_W  candidate slope (scaled)
- line_b  in  DATA_W  candidate intercept
- scale_factor  in  DATA_W  fixed-point scale
- threshold  in  DATA_W  squared-distance threshold
- num_points  in  ADDR_W+1  number of points to test
- pt_addr  out  ADDR_W  point RAM read address
- pt_rd  out  1  point RAM read strobe
- pt_x  in  DATA_W  point x; valid the cycle after pt_rd
- pt_y  in  DATA_W  point y; valid the cycle after pt_rd
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse
- inlier_count  out  ADDR_W+1  inlier count of the last run
- best_count  out  ADDR_W+1  highest count since clear
- best_a  out  DATA_W  line_a of the best line
- best_b  out  DATA_W  line_b of the best line
- best_valid  out  1  best registers hold a scored line

Behaviour:
- Reset: all outputs and internal registers are 0 and the state is IDLE. Reset applies at any time, including mid-run; an interrupted run produces no done.
- States:
  - IDLE → RUN when start=1 and num_points≠0.
  - IDLE → DONE when start=1 and num_points=0.
  - RUN issues addresses 0..N-1 on consecutive cycles with pt_rd=1, then → DRAIN.
  - DRAIN waits until the last result has been counted, then → DONE.
  - DONE pulses done for one cycle, then → IDLE.
- Operand capture: on accepted start, line_a, line_b, scale_factor, threshold and num_points are latched. Later changes to these inputs have no effect on the run. start outside IDLE is ignored.
- Counter clear: inlier_count is cleared on accepted start.
- Timing with start sampled in cycle T and N=num_points:
  - pt_addr=k, pt_rd=1 in cycle T+1+k.
  - Point k data arrives in T+2+k.
  - Test result is registered and valid in T+3+k.
  - done=1 in T+N+3, and inlier_count is final in that same cycle.
  - busy=1 for T+1..T+N+2.
  - For N=0: done=1 in T+1, count 0, no pt_rd.
- Inlier test, all arithmetic unsigned DATA_W with products truncated mod 2^DATA_W (matches the software model):
  - term1 = a·x − y·s + b·s
  - term2 = a·a + s·s
  - Point is an inlier iff (term1·term1)/term2 ≤ threshold.
  - term2=0 → outlier (no divide).
- Best tracking: in the DONE cycle, if inlier_count > best_count or best_valid=0, load best_count, best_a and best_b from this run and set best_valid=1. Ties keep the earlier line.
- clear_best: zeroes the best registers and best_valid in any state. If it coincides with a DONE update, clear wins.

Decomposition:
- Shared package ransac_pkg holds DATA_W and ADDR_W defaults and the state enum {IDLE, RUN, DRAIN, DONE}.
- One sub-module, inlier_test_pipe: the registered single-stage inlier test. Inputs are the latched operands plus a valid point; outputs are result_valid and is_inlier.
- The scorer contains the FSM, address counter, inlier counter and best registers.

Test Plan:
- Basic run: s=1, a=1, b=0, threshold=0, points (0,0),(1,1),(2,5),(3,3), start at T → pt_addr 0..3 in T+1..T+4; done at T+7; inlier_count=3; best_count=3, best_a=1, best_b=0, best_valid=1.
- Empty set: num_points=0 → done at T+1, inlier_count=0, pt_rd never asserted, busy never asserted; best_valid=1 with best_count=0.
- Best tracking: score lines giving counts 3, then 2, then 3 → best_a and best_b stay at the first line. clear_best followed by a run with count 1 → best_count=1.
- Degenerate line: a=0, s=0, four points, threshold=0xFFFFFFFF → inlier_count=0 (term2=0 forces outlier).
- Robustness: assert start while busy → ignored; changing line_a mid-run → count unchanged. Assert reset at T+3 → all outputs 0, no done; a fresh start then completes normally.
- Capacity: num_points=1024 → 1024 consecutive pt_rd cycles; done at T+1027; count wraps correctly through the full ADDR_W+1 width.

Source files
------------

// File: rtl/ransac_pkg.sv
// rtl/ransac_pkg.sv - shared defaults and state encoding for the RANSAC inlier scorer
package ransac_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 10;

    // Scorer sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/inlier_test_pipe.sv
// rtl/inlier_test_pipe.sv - registered single-stage point-to-line inlier test
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid        pt_x/pt_y carry a point to test this cycle
//   line_a, line_b  candidate slope (scaled) and intercept
//   scale_factor    fixed-point scale s
//   threshold       squared-distance threshold
//   pt_x, pt_y      point coordinates
//   result_valid    registered: a test result is present this cycle
//   is_inlier       registered: that point is an inlier
module inlier_test_pipe #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] line_a,
    input  logic [DATA_W-1:0] line_b,
    input  logic [DATA_W-1:0] scale_factor,
    input  logic [DATA_W-1:0] threshold,
    input  logic [DATA_W-1:0] pt_x,
    input  logic [DATA_W-1:0] pt_y,
    output logic              result_valid,
    output logic              is_inlier
);

    logic [DATA_W-1:0] term1;
    logic [DATA_W-1:0] term2;
    logic [DATA_W-1:0] term1_sq;
    logic [DATA_W-1:0] divisor;
    logic [DATA_W-1:0] quotient;
    logic              result_valid_d, result_valid_q;
    logic              is_inlier_d, is_inlier_q;

    // All products wrap mod 2^DATA_W to stay bit-exact with the software model.
    always_comb begin
        term1          = line_a * pt_x - pt_y * scale_factor + line_b * scale_factor;
        term2          = line_a * line_a + scale_factor * scale_factor;
        term1_sq       = term1 * term1;
        // Keep the divider fed with a nonzero value; term2 == 0 is rejected below.
        divisor        = (term2 == '0) ? DATA_W'(1) : term2;
        quotient       = term1_sq / divisor;
        result_valid_d = in_valid;
        is_inlier_d    = in_valid && (term2 != '0) && (quotient <= threshold);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_valid_q <= 1'b0;
            is_inlier_q    <= 1'b0;
        end else begin
            result_valid_q <= result_valid_d;
            is_inlier_q    <= is_inlier_d;
        end
    end

    assign result_valid = result_valid_q;
    assign is_inlier    = is_inlier_q;

endmodule

// File: rtl/ransac_inlier_scorer.sv
// rtl/ransac_inlier_scorer.sv - scores one candidate line over the point RAM and tracks the best line
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               begin a scoring run (sampled only in idle)
//   clear_best          zero the best-line registers
//   line_a, line_b      candidate line, captured on accepted start
//   scale_factor        fixed-point scale, captured on accepted start
//   threshold           squared-distance threshold, captured on accepted start
//   num_points          number of points to test, captured on accepted start
//   pt_addr, pt_rd      point RAM read address and strobe
//   pt_x, pt_y          point RAM read data, valid the cycle after pt_rd
//   busy                run in progress
//   done                one-cycle completion pulse
//   inlier_count        inlier count of the last run
//   best_count          highest count since the last clear
//   best_a, best_b      line of the best run
//   best_valid          best registers hold a scored line
module ransac_inlier_scorer
    import ransac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clear_best,
    input  logic [DATA_W-1:0] line_a,
    input  logic [DATA_W-1:0] line_b,
    input  logic [DATA_W-1:0] scale_factor,
    input  logic [DATA_W-1:0] threshold,
    input  logic [ADDR_W:0]   num_points,
    output logic [ADDR_W-1:0] pt_addr,
    output logic              pt_rd,
    input  logic [DATA_W-1:0] pt_x,
    input  logic [DATA_W-1:0] pt_y,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   inlier_count,
    output logic [ADDR_W:0]   best_count,
    output logic [DATA_W-1:0] best_a,
    output logic [DATA_W-1:0] best_b,
    output logic              best_valid
);

    localparam int CNT_W = ADDR_W + 1;

    state_t            state_d, state_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic              rd_d, rd_q;
    logic              rd_dly_d, rd_dly_q;
    logic [DATA_W-1:0] a_d, a_q;
    logic [DATA_W-1:0] b_d, b_q;
    logic [DATA_W-1:0] s_d, s_q;
    logic [DATA_W-1:0] thr_d, thr_q;
    logic [CNT_W-1:0]  n_d, n_q;
    logic              busy_d, busy_q;
    logic              done_d, done_q;
    logic [CNT_W-1:0]  count_d, count_q;
    logic [CNT_W-1:0]  best_cnt_d, best_cnt_q;
    logic [DATA_W-1:0] best_a_d, best_a_q;
    logic [DATA_W-1:0] best_b_d, best_b_q;
    logic              best_valid_d, best_valid_q;

    logic              res_valid;
    logic              res_inlier;

    // rd_dly_q marks the cycle in which the RAM presents the data for a read.
    inlier_test_pipe #(
        .DATA_W (DATA_W)
    ) u_test (
        .clk          (clk),
        .rst          (reset),
        .in_valid     (rd_dly_q),
        .line_a       (a_q),
        .line_b       (b_q),
        .scale_factor (s_q),
        .threshold    (thr_q),
        .pt_x         (pt_x),
        .pt_y         (pt_y),
        .result_valid (res_valid),
        .is_inlier    (res_inlier)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rd_d         = rd_q;
        rd_dly_d     = rd_q;
        a_d          = a_q;
        b_d          = b_q;
        s_d          = s_q;
        thr_d        = thr_q;
        n_d          = n_q;
        count_d      = count_q + CNT_W'(res_valid & res_inlier);
        best_cnt_d   = best_cnt_q;
        best_a_d     = best_a_q;
        best_b_d     = best_b_q;
        best_valid_d = best_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = line_a;
                    b_d     = line_b;
                    s_d     = scale_factor;
                    thr_d   = threshold;
                    n_d     = num_points;
                    count_d = '0;
                    addr_d  = '0;
                    if (num_points == '0) begin
                        state_d = ST_DONE;
                        rd_d    = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                        rd_d    = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if ({1'b0, addr_q} == n_q - CNT_W'(1)) begin
                    state_d = ST_DRAIN;
                    rd_d    = 1'b0;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                // Once no read data is entering the test stage, the final
                // result is being counted this cycle.
                if (!rd_dly_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                // Strict compare: ties keep the earlier line.
                if ((count_q > best_cnt_q) || !best_valid_q) begin
                    best_cnt_d   = count_q;
                    best_a_d     = a_q;
                    best_b_d     = b_q;
                    best_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (clear_best) begin
            best_cnt_d   = '0;
            best_a_d     = '0;
            best_b_d     = '0;
            best_valid_d = 1'b0;
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            rd_q         <= 1'b0;
            rd_dly_q     <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            s_q          <= '0;
            thr_q        <= '0;
            n_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            count_q      <= '0;
            best_cnt_q   <= '0;
            best_a_q     <= '0;
            best_b_q     <= '0;
            best_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rd_q         <= rd_d;
            rd_dly_q     <= rd_dly_d;
            a_q          <= a_d;
            b_q          <= b_d;
            s_q          <= s_d;
            thr_q        <= thr_d;
            n_q          <= n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            count_q      <= count_d;
            best_cnt_q   <= best_cnt_d;
            best_a_q     <= best_a_d;
            best_b_q     <= best_b_d;
            best_valid_q <= best_valid_d;
        end
    end

    assign pt_addr      = addr_q;
    assign pt_rd        = rd_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign inlier_count = count_q;
    assign best_count   = best_cnt_q;
    assign best_a       = best_a_q;
    assign best_b       = best_b_q;
    assign best_valid   = best_valid_q;

endmodule

// File: tb/tb_ransac_inlier_scorer.sv
// tb/tb_ransac_inlier_scorer.sv - self-checking bench for ransac_inlier_scorer
module tb_ransac_inlier_scorer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        clear_best;
    logic [31:0] line_a, line_b, scale_factor, threshold;
    logic [10:0] num_points;
    logic [9:0]  pt_addr;
    logic        pt_rd;
    logic [31:0] pt_x, pt_y;
    logic        busy, done;
    logic [10:0] inlier_count, best_count;
    logic [31:0] best_a, best_b;
    logic        best_valid;

    ransac_inlier_scorer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .clear_best   (clear_best),
        .line_a       (line_a),
        .line_b       (line_b),
        .scale_factor (scale_factor),
        .threshold    (threshold),
        .num_points   (num_points),
        .pt_addr      (pt_addr),
        .pt_rd        (pt_rd),
        .pt_x         (pt_x),
        .pt_y         (pt_y),
        .busy         (busy),
        .done         (done),
        .inlier_count (inlier_count),
        .best_count   (best_count),
        .best_a       (best_a),
        .best_b       (best_b),
        .best_valid   (best_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Point RAM with one-cycle read latency.
    logic [31:0] mem_x [1024];
    logic [31:0] mem_y [1024];
    always @(posedge clk) begin
        if (pt_rd) begin
            pt_x <= mem_x[pt_addr];
            pt_y <= mem_y[pt_addr];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Cycle monitor: samples 1 time unit after each rising edge.
    int cyc = 0;
    int rd_cnt, first_rd, addr_err, busy_cnt, done_cnt, done_at, done_val;
    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (pt_rd) begin
            if (int'(pt_addr) != rd_cnt) addr_err++;
            if (rd_cnt == 0) first_rd = cyc;
            rd_cnt++;
        end
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            if (done_at < 0) begin
                done_at  = cyc;
                done_val = int'(inlier_count);
            end
        end
    end

    // Reference best-line state.
    int          mb_cnt;
    logic [31:0] mb_a, mb_b;
    bit          mb_valid;

    task automatic chk(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic bit ref_inlier(input logic [31:0] a, b, s, thr, x, y);
        logic [31:0] t1, t2, sq;
        t1 = a * x - y * s + b * s;
        t2 = a * a + s * s;
        sq = t1 * t1;
        if (t2 == 0) return 1'b0;
        return (sq / t2) <= thr;
    endfunction

    function automatic int ref_count(input logic [31:0] a, b, s, thr, input int n);
        int c = 0;
        for (int k = 0; k < n; k++) c += int'(ref_inlier(a, b, s, thr, mem_x[k], mem_y[k]));
        return c;
    endfunction

    function automatic void model_best(input int cnt, input logic [31:0] a, b);
        if (cnt > mb_cnt || !mb_valid) begin
            mb_cnt = cnt; mb_a = a; mb_b = b; mb_valid = 1'b1;
        end
    endfunction

    function automatic void reset_monitors();
        rd_cnt = 0; first_rd = -1; addr_err = 0; busy_cnt = 0;
        done_cnt = 0; done_at = -1; done_val = -1;
    endfunction

    task automatic pulse_clear();
        @(negedge clk); clear_best = 1'b1;
        @(negedge clk); clear_best = 1'b0;
        mb_cnt = 0; mb_a = '0; mb_b = '0; mb_valid = 1'b0;
        chk("clear_best_valid", best_valid, 0);
        chk("clear_best_count", best_count, 0);
    endtask

    // mode 0: plain run; 1: start pulse and operand changes mid-run;
    // 2: clear_best coincides with the done cycle.
    task automatic do_run(input logic [31:0] a, b, s, thr, input int n, input int mode,
                          input int exp_cnt);
        int t0;
        @(negedge clk);
        line_a = a; line_b = b; scale_factor = s; threshold = thr;
        num_points = 11'(n); start = 1'b1;
        t0 = cyc;
        reset_monitors();
        @(negedge clk);
        start = 1'b0;
        while (done_at < 0 && cyc < t0 + n + 40) begin
            @(negedge clk);
            if (mode == 1 && cyc == t0 + 2) begin
                start = 1'b1; line_a = a + 32'd5; line_b = b + 32'd3;
                threshold = 32'hFFFF_FFFF; scale_factor = s + 32'd1; num_points = 11'd2;
            end
            if (mode == 1 && cyc == t0 + 4) start = 1'b0;
        end
        if (mode == 2) begin
            clear_best = 1'b1;
            @(negedge clk);
            clear_best = 1'b0;
        end
        repeat (3) @(negedge clk);

        chk("done_cycle", done_at - t0, (n == 0) ? 1 : n + 3);
        chk("done_pulses", done_cnt, 1);
        chk("inlier_count_at_done", done_val, exp_cnt);
        chk("inlier_count_held", inlier_count, exp_cnt);
        chk("pt_rd_cycles", rd_cnt, n);
        chk("pt_addr_sequence_errors", addr_err, 0);
        chk("busy_cycles", busy_cnt, (n == 0) ? 0 : n + 2);
        if (n > 0) chk("first_pt_rd_cycle", first_rd - t0, 1);

        if (mode == 2) begin
            mb_cnt = 0; mb_a = '0; mb_b = '0; mb_valid = 1'b0;
        end else begin
            model_best(exp_cnt, a, b);
        end
        chk("best_count", best_count, mb_cnt);
        chk("best_a", best_a, mb_a);
        chk("best_b", best_b, mb_b);
        chk("best_valid", best_valid, mb_valid);
    endtask

    typedef struct {
        logic [31:0] a, b, s, thr;
        int          n;
        bit          clr;
        int          exp_cnt;
        int          exp_bc;
        logic [31:0] exp_ba, exp_bb;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int t0, exp;
        logic [31:0] ra, rb, rs, rt;
        int rn;

        reset = 1'b1; start = 1'b0; clear_best = 1'b0;
        line_a = '0; line_b = '0; scale_factor = '0; threshold = '0; num_points = '0;
        mb_cnt = 0; mb_a = '0; mb_b = '0; mb_valid = 1'b0;
        reset_monitors();
        for (int k = 0; k < 1024; k++) begin mem_x[k] = '0; mem_y[k] = '0; end

        repeat (3) @(negedge clk);
        chk("reset_pt_rd", pt_rd, 0);
        chk("reset_pt_addr", pt_addr, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_inlier_count", inlier_count, 0);
        chk("reset_best_count", best_count, 0);
        chk("reset_best_valid", best_valid, 0);
        reset = 1'b0;

        mem_x[0] = 0; mem_y[0] = 0;
        mem_x[1] = 1; mem_y[1] = 1;
        mem_x[2] = 2; mem_y[2] = 5;
        mem_x[3] = 3; mem_y[3] = 3;

        //        a      b      s      thr            n  clr cnt bc  ba     bb
        tbl[0] = '{32'd7, 32'd9, 32'd1, 32'd0,         0, 0,  0,  0, 32'd7, 32'd9};
        tbl[1] = '{32'd1, 32'd0, 32'd1, 32'd0,         4, 0,  3,  3, 32'd1, 32'd0};
        tbl[2] = '{32'd0, 32'd1, 32'd1, 32'd1,         4, 0,  2,  3, 32'd1, 32'd0};
        tbl[3] = '{32'd1, 32'd1, 32'd1, 32'd0,         4, 0,  3,  3, 32'd1, 32'd0};
        tbl[4] = '{32'd0, 32'd5, 32'd0, 32'hFFFF_FFFF, 4, 0,  0,  3, 32'd1, 32'd0};
        tbl[5] = '{32'd0, 32'd0, 32'd1, 32'd0,         4, 1,  1,  1, 32'd0, 32'd0};

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].clr) pulse_clear();
            do_run(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].thr, tbl[i].n, 0, tbl[i].exp_cnt);
            chk($sformatf("tbl%0d_best_count", i), best_count, tbl[i].exp_bc);
            chk($sformatf("tbl%0d_best_a", i), best_a, tbl[i].exp_ba);
            chk($sformatf("tbl%0d_best_b", i), best_b, tbl[i].exp_bb);
            chk($sformatf("tbl%0d_best_valid", i), best_valid, 1);
        end

        // Start while busy and operand changes mid-run have no effect.
        do_run(32'd1, 32'd0, 32'd1, 32'd0, 4, 1, 3);

        // clear_best in the done cycle beats the best update.
        do_run(32'd1, 32'd0, 32'd1, 32'd0, 4, 2, 3);

        // Reset in the middle of a run.
        @(negedge clk);
        line_a = 32'd1; line_b = 32'd0; scale_factor = 32'd1; threshold = 32'd0;
        num_points = 11'd4; start = 1'b1;
        t0 = cyc;
        reset_monitors();
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset_pt_rd", pt_rd, 0);
        chk("midreset_pt_addr", pt_addr, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_done", done, 0);
        chk("midreset_inlier_count", inlier_count, 0);
        chk("midreset_best_valid", best_valid, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("midreset_no_done", done_cnt, 0);
        mb_cnt = 0; mb_a = '0; mb_b = '0; mb_valid = 1'b0;
        do_run(32'd1, 32'd0, 32'd1, 32'd0, 4, 0, 3);

        // Randomized lines and point sets against the reference model.
        for (int r = 0; r < 24; r++) begin
            for (int k = 0; k < 64; k++) begin
                mem_x[k] = $urandom_range(0, 15);
                mem_y[k] = (r % 6 == 5) ? $urandom() : $urandom_range(0, 15);
            end
            if (r % 5 == 4) begin
                ra = $urandom(); rb = $urandom(); rs = $urandom(); rt = $urandom();
            end else begin
                ra = $urandom_range(0, 3); rb = $urandom_range(0, 3);
                rs = $urandom_range(0, 3); rt = $urandom_range(0, 40);
            end
            rn = $urandom_range(1, 64);
            if (r == 12) pulse_clear();
            exp = ref_count(ra, rb, rs, rt, rn);
            do_run(ra, rb, rs, rt, rn, 0, exp);
        end

        // Full capacity: every point is an inlier, count needs the top bit.
        for (int k = 0; k < 1024; k++) begin
            mem_x[k] = $urandom();
            mem_y[k] = $urandom();
        end
        exp = ref_count(32'd0, 32'd0, 32'd1, 32'hFFFF_FFFF, 1024);
        chk("capacity_model_sanity", exp, 1024);
        do_run(32'd0, 32'd0, 32'd1, 32'hFFFF_FFFF, 1024, 0, 1024);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
